// File: rtl/bn_down_counter.sv
// Modulo-MODULUS down-counter stage with ei/eu borrow chaining, clamped parallel load and a
// registered terminal-count pulse. Define BN_DOWN_COUNTER_SAT_EN to saturate at zero instead of wrapping.
`timescale 1ns/1ps
module bn_down_counter #(
   parameter int N       = 4,
   parameter int MODULUS = 16
) (
   input  logic         clock,
   input  logic         reset_,
   input  logic         ei,
   input  logic         ld,
   input  logic [N-1:0] din,
   output logic [N-1:0] q,
   output logic         eu,
   output logic         zero,
   output logic         tc
);

   localparam logic [N-1:0] ZERO_C = {N{1'b0}};
   localparam logic [N-1:0] ONE_C  = N'(1);
   localparam logic [N-1:0] MAX_C  = N'(MODULUS - 1);

   logic [N-1:0] count_q;
   logic [N-1:0] count_d;
   logic         tc_q;
   logic         tc_d;
   logic         at_zero_s;

   assign at_zero_s = (count_q == ZERO_C);

   // Next-state selection: load beats decrement, decrement beats hold.
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (ld) begin
         // din >= MODULUS clamps to the top of the range.
         if (din > MAX_C) begin
            count_d = MAX_C;
         end else begin
            count_d = din;
         end
      end else if (ei) begin
         if (!at_zero_s) begin
            count_d = count_q - ONE_C;
         end else begin
`ifdef BN_DOWN_COUNTER_SAT_EN
            count_d = ZERO_C;
`else
            count_d = MAX_C;
`endif
            tc_d    = 1'b1;
         end
      end else begin
         count_d = count_q;
      end
   end

   // State register with synchronous active-low reset taking priority over everything.
   always_ff @(posedge clock) begin
      if (!reset_) begin
         count_q <= ZERO_C;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   // Borrow-out is combinational so a chain of stages ripples within one cycle.
   assign eu   = ei & ~ld & at_zero_s;
   assign zero = at_zero_s;
   assign q    = count_q;
   assign tc   = tc_q;

endmodule

// File: tb/tb_bn_down_counter.sv
// Directed self-checking bench for bn_down_counter (N=4, MODULUS=10), single stage and a two-stage chain.
`timescale 1ns/1ps
module tb_bn_down_counter;

   logic       clock = 1'b0;
   logic       reset_;
   logic       ei, ld;
   logic [3:0] din;
   logic [3:0] q;
   logic       eu, zero, tc;

   logic       ld_c, cnt_en;
   logic [3:0] din_ones, din_tens;
   logic [3:0] q_ones, q_tens;
   logic       eu_ones, eu_tens, zero_ones, zero_tens, tc_ones, tc_tens;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   bn_down_counter #(.N(4), .MODULUS(10)) dut (
      .clock(clock), .reset_(reset_), .ei(ei), .ld(ld), .din(din),
      .q(q), .eu(eu), .zero(zero), .tc(tc)
   );

   bn_down_counter #(.N(4), .MODULUS(10)) u_ones (
      .clock(clock), .reset_(reset_), .ei(cnt_en), .ld(ld_c), .din(din_ones),
      .q(q_ones), .eu(eu_ones), .zero(zero_ones), .tc(tc_ones)
   );

   bn_down_counter #(.N(4), .MODULUS(10)) u_tens (
      .clock(clock), .reset_(reset_), .ei(eu_ones), .ld(ld_c), .din(din_tens),
      .q(q_tens), .eu(eu_tens), .zero(zero_tens), .tc(tc_tens)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int tc_seen;
      int tc_edge[2];
      int exp_q;
      reset_ = 1'b0; ei = 1'b0; ld = 1'b0; din = 4'd0;
      ld_c = 1'b0; cnt_en = 1'b0; din_ones = 4'd0; din_tens = 4'd0;
      step();
      check("reset_q", q, 4'd0);
      check("reset_tc", tc, 1'b0);
      check("reset_zero", zero, 1'b1);
      check("reset_chain", {q_tens, q_ones}, 8'h00);

      // load then count down
      reset_ = 1'b1; ld = 1'b1; din = 4'd3;
      step();
      check("load3_q", q, 4'd3);
      check("load3_zero", zero, 1'b0);
      ld = 1'b0; ei = 1'b1;
      #1 check("eu_nonzero", eu, 1'b0);
      step(); check("dec_q2", q, 4'd2);
      step(); check("dec_q1", q, 4'd1);
      step(); check("dec_q0", q, 4'd0);
      check("dec_zero", zero, 1'b1);
      check("eu_at_zero", eu, 1'b1);
      check("tc_before_wrap", tc, 1'b0);
`ifndef BN_DOWN_COUNTER_SAT_EN
      step();
      check("wrap_q9", q, 4'd9);
      check("wrap_tc", tc, 1'b1);
      check("wrap_eu_off", eu, 1'b0);
      ei = 1'b0;
      step();
      check("hold_q9", q, 4'd9);
      check("tc_one_cycle", tc, 1'b0);
`else
      step();
      check("sat_q0_a", q, 4'd0);
      check("sat_tc_a", tc, 1'b1);
      check("sat_eu_a", eu, 1'b1);
      step();
      check("sat_q0_b", q, 4'd0);
      check("sat_tc_b", tc, 1'b1);
      ei = 1'b0;
      #1 check("sat_eu_idle", eu, 1'b0);
      step();
      check("sat_tc_drop", tc, 1'b0);
      check("sat_hold_q0", q, 4'd0);
      // saturation from q=1 over three enabled edges
      ld = 1'b1; din = 4'd1;
      step();
      ld = 1'b0; ei = 1'b1;
      step(); check("sat1_q", q, 4'd0); check("sat1_tc", tc, 1'b0); check("sat1_eu", eu, 1'b1);
      step(); check("sat2_q", q, 4'd0); check("sat2_tc", tc, 1'b1);
      step(); check("sat3_q", q, 4'd0); check("sat3_tc", tc, 1'b1); check("sat3_eu", eu, 1'b1);
      ei = 1'b0;
      step();
`endif

      // clamp and load-over-decrement priority
      ld = 1'b1; din = 4'd12;
      step();
      check("clamp_q", q, 4'd9);
      check("clamp_tc", tc, 1'b0);
      ld = 1'b1; din = 4'd15;
      step();
      check("clamp15_q", q, 4'd9);
      din = 4'd0;
      step();
      check("load0_q", q, 4'd0);
      ld = 1'b1; ei = 1'b1; din = 4'd5;
      #1 check("eu_blocked_by_ld", eu, 1'b0);
      step();
      check("ld_over_ei_q", q, 4'd5);
      check("ld_over_ei_tc", tc, 1'b0);

      // reset mid-count and mid-load
      ld = 1'b1; ei = 1'b0; din = 4'd6;
      step();
      check("load6_q", q, 4'd6);
      ld = 1'b0; ei = 1'b1; reset_ = 1'b0;
      step();
      check("rst_midcount_q", q, 4'd0);
      check("rst_midcount_tc", tc, 1'b0);
      ei = 1'b0; ld = 1'b1; din = 4'd7;
      step();
      check("rst_over_ld_q", q, 4'd0);
      // reset also suppresses the wrap and its tc
      ld = 1'b0; ei = 1'b1;
      step();
      check("rst_over_wrap_q", q, 4'd0);
      check("rst_over_wrap_tc", tc, 1'b0);
      reset_ = 1'b1; ei = 1'b0;

`ifndef BN_DOWN_COUNTER_SAT_EN
      // 25 enabled edges from 9: the load is edge 1
      ld = 1'b1; din = 4'd9;
      step();
      ld = 1'b0; ei = 1'b1;
      tc_seen = 0; tc_edge[0] = 0; tc_edge[1] = 0;
      for (int k = 2; k <= 26; k++) begin
         step();
         exp_q = (9 - (k - 1) + 30) % 10;
         check($sformatf("run_q_e%0d", k), q, exp_q);
         if (tc === 1'b1) begin
            if (tc_seen < 2) tc_edge[tc_seen] = k;
            tc_seen++;
         end
      end
      ei = 1'b0;
      check("run_tc_count", tc_seen, 2);
      check("run_tc_edge0", tc_edge[0], 11);
      check("run_tc_edge1", tc_edge[1], 21);

      // two-stage chain: load 20, one count -> 19
      ld_c = 1'b1; din_ones = 4'd0; din_tens = 4'd2;
      step();
      check("chain_load", {q_tens, q_ones}, 8'h20);
      ld_c = 1'b0; cnt_en = 1'b1;
      #1;
      check("chain_eu_ones", eu_ones, 1'b1);
      check("chain_eu_tens", eu_tens, 1'b0);
      step();
      check("chain_19", {q_tens, q_ones}, 8'h19);
      check("chain_tc_ones", tc_ones, 1'b1);
      check("chain_tc_tens", tc_tens, 1'b0);
      cnt_en = 1'b0;
      step();
      check("chain_hold", {q_tens, q_ones}, 8'h19);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
